// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Writeback arbiter that drives the register file write port.
//
// Two result sources compete for the write port:
//   - the single-cycle ALU path, granted directly (fixed priority);
//   - the long-latency memory/mul path, buffered in a DEPTH-entry FIFO.
//
// An anti-starvation counter tracks how many consecutive cycles a non-empty
// FIFO head has lost to the ALU. Once it reaches STARVE_LIMIT, the ALU is
// stalled (alu_ready=0) for one cycle and the FIFO head is forced through.
//
// Parameters:
//   DEPTH        memory-path FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT cycles a FIFO head may lose before it is forced (>= 1)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_valid/ready/rd/val      ALU result handshake and payload
//   mem_valid/ready/rd/val      memory-path result handshake and payload
//   rd, write_val, write_enable registered regfile write port
//   busy                        FIFO non-empty
//
// Optional feature (macro REGFILE_WRITEBACK_FWD_EN):
//   fwd_rs1/fwd_rs2             decode-stage source indices
//   fwd_rsN_hit/fwd_rsN_val     combinational bypass of the value being
//                               written this cycle
// ---------------------------------------------------------------------------
module regfile_writeback #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_val,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_val,
   output logic [4:0]  rd,
   output logic [31:0] write_val,
   output logic        write_enable,
   output logic        busy
`ifdef REGFILE_WRITEBACK_FWD_EN
   ,
   input  logic [4:0]  fwd_rs1,
   input  logic [4:0]  fwd_rs2,
   output logic        fwd_rs1_hit,
   output logic        fwd_rs2_hit,
   output logic [31:0] fwd_rs1_val,
   output logic [31:0] fwd_rs2_val
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   // FIFO storage (data only, never reset)
   logic [4:0]       r_fifo_rd  [DEPTH];
   logic [31:0]      r_fifo_val [DEPTH];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [SC_W-1:0]  r_starve;

   logic [4:0]       r_rd;
   logic [31:0]      r_wval;
   logic             r_we;

   logic             w_full;
   logic             w_busy;
   logic             w_forced;
   logic             w_grant_alu;
   logic             w_grant_mem;
   logic             w_push;
   logic [4:0]       w_g_rd;
   logic [31:0]      w_g_val;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_busy   = (r_count != '0);
   assign w_forced = w_busy && (r_starve >= SC_W'(STARVE_LIMIT));

   // Ready signals depend on state only, never on the incoming valids.
   assign alu_ready = !w_forced;
   assign mem_ready = !w_full;
   assign busy      = w_busy;

   assign w_grant_alu = alu_valid && !w_forced;
   assign w_grant_mem = !w_grant_alu && w_busy;
   assign w_push      = mem_valid && !w_full;

   assign w_g_rd  = w_grant_alu ? alu_rd  : r_fifo_rd[r_rd_ptr];
   assign w_g_val = w_grant_alu ? alu_val : r_fifo_val[r_rd_ptr];

   // FIFO data write; a pushed entry becomes visible at the head next cycle.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]  <= mem_rd;
         r_fifo_val[r_wr_ptr] <= mem_val;
      end
   end

   // FIFO control: pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_grant_mem)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_grant_mem})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Anti-starvation counter: counts consecutive ALU wins over a waiting head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
      end else if (!w_busy || w_grant_mem) begin
         r_starve <= '0;
      end else if (w_grant_alu && (r_starve != SC_W'(STARVE_LIMIT))) begin
         r_starve <= r_starve + SC_W'(1);
      end
   end

   // Output register: x0 grants are consumed but never strobed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd   <= '0;
         r_wval <= '0;
         r_we   <= 1'b0;
      end else if (w_grant_alu || w_grant_mem) begin
         r_rd   <= w_g_rd;
         r_wval <= w_g_val;
         r_we   <= (w_g_rd != 5'd0);
      end else begin
         r_we   <= 1'b0;
      end
   end

   assign rd           = r_rd;
   assign write_val    = r_wval;
   assign write_enable = r_we;

`ifdef REGFILE_WRITEBACK_FWD_EN
   assign fwd_rs1_hit = r_we && (r_rd == fwd_rs1) && (fwd_rs1 != 5'd0);
   assign fwd_rs2_hit = r_we && (r_rd == fwd_rs2) && (fwd_rs2 != 5'd0);
   assign fwd_rs1_val = fwd_rs1_hit ? r_wval : 32'd0;
   assign fwd_rs2_val = fwd_rs2_hit ? r_wval : 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//
// Self-checking bench for regfile_writeback (DEPTH=4, STARVE_LIMIT=3).
// Accepted results are pushed to per-source expectation queues; every strobed
// regfile write is popped and compared. Directed checks cover reset, latency,
// starvation forcing, FIFO full, x0 writes and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_val;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_val;
   logic [4:0]  rd;
   logic [31:0] write_val;
   logic        write_enable;
   logic        busy;
`ifdef REGFILE_WRITEBACK_FWD_EN
   logic [4:0]  fwd_rs1;
   logic [4:0]  fwd_rs2;
   logic        fwd_rs1_hit;
   logic        fwd_rs2_hit;
   logic [31:0] fwd_rs1_val;
   logic [31:0] fwd_rs2_val;
`endif

   int n_checks = 0;
   int n_err    = 0;

   logic [36:0] aq[$];
   logic [36:0] mq[$];

   regfile_writeback #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_val      (alu_val),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rd       (mem_rd),
      .mem_val      (mem_val),
      .rd           (rd),
      .write_val    (write_val),
      .write_enable (write_enable),
      .busy         (busy)
`ifdef REGFILE_WRITEBACK_FWD_EN
      ,
      .fwd_rs1      (fwd_rs1),
      .fwd_rs2      (fwd_rs2),
      .fwd_rs1_hit  (fwd_rs1_hit),
      .fwd_rs2_hit  (fwd_rs2_hit),
      .fwd_rs1_val  (fwd_rs1_val),
      .fwd_rs2_val  (fwd_rs2_val)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: sample at negedge, away from the active edge.
   // ALU and memory-path destination registers are kept disjoint per test,
   // so the rd of a write selects which stream it must belong to.
   always @(negedge clk) begin
      logic [36:0] got;
      logic [36:0] exp;
      if (write_enable) begin
         got = {rd, write_val};
         if (aq.size() > 0 && aq[0][36:32] == rd) begin
            exp = aq.pop_front();
            check("sb_write_alu", 64'(got), 64'(exp));
         end else if (mq.size() > 0) begin
            exp = mq.pop_front();
            check("sb_write_mem", 64'(got), 64'(exp));
         end else begin
            check("sb_unexpected_write", 64'(got), 64'h0);
         end
      end
      if (rst) begin
         aq.delete();
         mq.delete();
      end else begin
         if (alu_valid && alu_ready && alu_rd != 5'd0)
            aq.push_back({alu_rd, alu_val});
         if (mem_valid && mem_ready && mem_rd != 5'd0)
            mq.push_back({mem_rd, mem_val});
      end
   end

   task automatic drain(input string tag);
      int waited;
      waited = 0;
      while (busy && waited < 50) begin
         tick();
         waited++;
      end
      if (busy)
         check({tag, "_drain_timeout"}, 64'(busy), 64'd0);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int k;
      int ar;
      logic acc_a;
      logic acc_m;

      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_val = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_val = '0;
`ifdef REGFILE_WRITEBACK_FWD_EN
      fwd_rs1 = '0; fwd_rs2 = '0;
`endif
      tick();
      tick();

      // Reset state
      check("rst_we",        64'(write_enable), 64'd0);
      check("rst_rd",        64'(rd),           64'd0);
      check("rst_wval",      64'(write_val),    64'd0);
      check("rst_busy",      64'(busy),         64'd0);
      check("rst_mem_ready", 64'(mem_ready),    64'd1);
      check("rst_alu_ready", 64'(alu_ready),    64'd1);
      rst = 1'b0;
      tick();

      // Single ALU write: 1-cycle latency, then strobe drops, data holds
      alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      check("alu_we",   64'(write_enable), 64'd1);
      check("alu_rd",   64'(rd),           64'd5);
      check("alu_wval", 64'(write_val),    64'hDEADBEEF);
      tick();
      check("alu_we_drop", 64'(write_enable), 64'd0);
      check("alu_rd_hold", 64'(rd),           64'd5);
      check("alu_wv_hold", 64'(write_val),    64'hDEADBEEF);

      // Single memory push: write exactly two cycles after the push cycle
      mem_valid = 1'b1; mem_rd = 5'd7; mem_val = 32'h11;
      check("mem_ready_empty", 64'(mem_ready), 64'd1);
      tick();
      mem_valid = 1'b0;
      check("mem_busy_1",   64'(busy),         64'd1);
      check("mem_we_early", 64'(write_enable), 64'd0);
      tick();
      check("mem_we",     64'(write_enable), 64'd1);
      check("mem_rd",     64'(rd),           64'd7);
      check("mem_wval",   64'(write_val),    64'h11);
      check("mem_busy_0", 64'(busy),         64'd0);
      tick();

      // Starvation: ALU valid every cycle, one memory entry waiting
      r = 1;
      alu_valid = 1'b1; alu_rd = 5'(r); alu_val = 32'h100 + 32'(r);
      mem_valid = 1'b1; mem_rd = 5'd9; mem_val = 32'h900;
      for (int c = 0; c < 16 && r <= 8; c++) begin
         acc_a = alu_ready;
         if (c == 4)
            check("starve_forced", 64'(alu_ready), 64'd0);
         else if (c < 6)
            check("starve_alu_ready", 64'(alu_ready), 64'd1);
         tick();
         if (c == 0) mem_valid = 1'b0;
         if (c == 3) check("starve_rd4", 64'(rd), 64'd4);
         if (c == 4) check("starve_rd9", 64'(rd), 64'd9);
         if (c == 5) check("starve_resume_rd5", 64'(rd), 64'd5);
         if (acc_a) begin
            r++;
            alu_rd = 5'(r); alu_val = 32'h100 + 32'(r);
         end
      end
      alu_valid = 1'b0;
      drain("starve");

      // Fill FIFO while the ALU keeps winning; full with simultaneous pop
      ar = 10; k = 0;
      alu_valid = 1'b1; alu_rd = 5'(ar); alu_val = 32'h1000 + 32'(ar);
      mem_valid = 1'b1; mem_rd = 5'd24; mem_val = 32'hA000_0000;
      for (int c = 0; c < 30 && (k < 5 || ar <= 15); c++) begin
         if (c == 0) check("fill_ready_empty", 64'(mem_ready), 64'd1);
         if (c == 4) check("fill_full",        64'(mem_ready), 64'd0);
         if (c == 4) check("fill_forced",      64'(alu_ready), 64'd0);
         if (c == 5) check("fill_ready_again", 64'(mem_ready), 64'd1);
         acc_a = alu_valid && alu_ready;
         acc_m = mem_valid && mem_ready;
         tick();
         if (acc_a) begin
            ar++;
            if (ar > 15) alu_valid = 1'b0;
            alu_rd = 5'(ar); alu_val = 32'h1000 + 32'(ar);
         end
         if (acc_m) begin
            k++;
            if (k >= 5) mem_valid = 1'b0;
            mem_rd = 5'(24 + k); mem_val = 32'hA000_0000 + 32'(k);
         end
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      drain("fill");

      // x0 writes: consumed and popped, never strobed
      alu_valid = 1'b1; alu_rd = 5'd0; alu_val = 32'hFFFFFFFF;
      check("x0_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      check("x0_alu_we",   64'(write_enable), 64'd0);
      check("x0_alu_rd",   64'(rd),           64'd0);
      check("x0_alu_wval", 64'(write_val),    64'hFFFFFFFF);
      mem_valid = 1'b1; mem_rd = 5'd0; mem_val = 32'h55;
      tick();
      mem_valid = 1'b0;
      check("x0_mem_busy", 64'(busy), 64'd1);
      tick();
      check("x0_mem_popped", 64'(busy),         64'd0);
      check("x0_mem_we",     64'(write_enable), 64'd0);
      tick();

      // Mid-operation reset with three entries queued
      ar = 20; k = 0;
      alu_valid = 1'b1; alu_rd = 5'(ar); alu_val = 32'h2000 + 32'(ar);
      mem_valid = 1'b1; mem_rd = 5'd29; mem_val = 32'hB000_0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         ar++; k++;
         alu_rd = 5'(ar); alu_val = 32'h2000 + 32'(ar);
         mem_rd = 5'(29 + k); mem_val = 32'hB000_0000 + 32'(k);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      check("prerst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy",      64'(busy),         64'd0);
      check("mrst_we",        64'(write_enable), 64'd0);
      check("mrst_mem_ready", 64'(mem_ready),    64'd1);
      check("mrst_rd",        64'(rd),           64'd0);
      check("mrst_wval",      64'(write_val),    64'd0);
      repeat (8) tick();
      check("mrst_still_idle", 64'(busy), 64'd0);

`ifdef REGFILE_WRITEBACK_FWD_EN
      // Forwarding of the value being written this cycle
      alu_valid = 1'b1; alu_rd = 5'd4; alu_val = 32'h1234;
      tick();
      alu_valid = 1'b0;
      fwd_rs1 = 5'd4; fwd_rs2 = 5'd0;
      #1;
      check("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'd1);
      check("fwd_rs1_val", 64'(fwd_rs1_val), 64'h1234);
      check("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'd0);
      check("fwd_rs2_val", 64'(fwd_rs2_val), 64'd0);
      tick();
      check("fwd_rs1_nohit", 64'(fwd_rs1_hit), 64'd0);
`endif

      tick();
      tick();
      check("sb_alu_left", 64'(aq.size()), 64'd0);
      check("sb_mem_left", 64'(mq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
